// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, issues credit-limited word fetches, buffers responses and feeds decode
// Ports: clk, rst (sync, active-low); imem_req_* fetch request channel; imem_rsp_* in-order
//        response channel; redirect_valid/redirect_pc control-flow change; stall decode backpressure;
//        inst_valid/instruction/inst_pc decode-facing output; misaligned_fault sticky bad-target flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        misaligned_fault
);
    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [CW:0] LIM = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_rpc;
    logic [31:0]   r_data [FIFO_DEPTH];
    logic [31:0]   r_ipc  [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic          r_fault;

    logic          w_run;
    logic          w_acc;
    logic          w_rsp;
    logic          w_redir;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_nxt;

    // Credit covers both buffered and in-flight words, so a response always finds a free slot.
    assign w_run            = r_state == RUN;
    assign imem_req_valid   = rst && w_run && (({1'b0, r_out} + {1'b0, r_cnt}) < LIM);
    assign imem_req_addr    = r_pc;
    assign w_acc            = imem_req_valid && imem_req_ready;
    assign w_rsp            = imem_rsp_valid && (r_out != '0);
    assign w_redir          = w_run && redirect_valid;
    assign w_push           = w_rsp && (r_drop == '0) && w_run && !redirect_valid;
    assign w_pop            = inst_valid && !stall && !redirect_valid;
    assign w_out_nxt        = r_out + CW'(w_acc) - CW'(w_rsp);
    assign inst_valid       = r_cnt != '0;
    assign instruction      = inst_valid ? r_data[r_rp] : '0;
    assign inst_pc          = inst_valid ? r_ipc[r_rp] : '0;
    assign misaligned_fault = r_fault;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_rpc   <= RESET_PC;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_drop  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_acc)
                r_pc <= r_pc + 32'd4;
            if (w_rsp && r_drop != '0)
                r_drop <= r_drop - 1'b1;
            if (w_push) begin
                r_data[r_wp] <= imem_rsp_data;
                r_ipc[r_wp]  <= r_rpc;
                r_wp         <= r_wp + 1'b1;
                r_rpc        <= r_rpc + 32'd4;
            end
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            // Every word still owed by memory belongs to the old stream and must be dropped.
            if (w_redir) begin
                r_pc   <= redirect_pc;
                r_rpc  <= redirect_pc;
                r_drop <= w_out_nxt;
                r_cnt  <= '0;
                r_wp   <= '0;
                r_rp   <= '0;
                if (redirect_pc[1:0] != 2'b00) begin
                    r_fault <= 1'b1;
                    r_state <= HALT;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with an in-order latency-configurable memory
module tb_fetch_unit;
    logic        clk = 0, rst = 0;
    logic        imem_req_valid, imem_req_ready = 0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        stall = 0;
    logic        inst_valid;
    logic [31:0] instruction, inst_pc;
    logic        misaligned_fault;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid(inst_valid), .instruction(instruction), .inst_pc(inst_pc),
        .misaligned_fault(misaligned_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    typedef struct { logic [31:0] a; int due; } req_t;
    req_t q[$];
    int   lat = 1;
    bit   cdata = 0;
    int   mcyc = 0;

    function automatic logic [31:0] dfn(input logic [31:0] a);
        return cdata ? 32'h0000_0013 : (a ^ 32'h5A5A_0013);
    endfunction

    // Memory: accepts every request, answers in order no earlier than lat cycles later, resets with the DUT.
    always @(posedge clk) begin
        if (imem_rsp_valid && q.size() > 0) q.delete(0);
        if (imem_req_valid && imem_req_ready) q.push_back('{imem_req_addr, mcyc + lat});
        mcyc++;
        if (!rst) q.delete();
        #1;
        if (q.size() > 0 && q[0].due <= mcyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data  = dfn(q[0].a);
        end else begin
            imem_rsp_valid = 0;
            imem_rsp_data  = 0;
        end
    end

    logic [31:0] pcs[$], ins[$], accs[$];
    int   max_out, redir_at, first_rsp, first_iv;
    logic iv_after;

    task automatic clear_log();
        pcs.delete(); ins.delete(); accs.delete();
        max_out = 0; redir_at = -1; first_rsp = -1; first_iv = -1; iv_after = 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 0; redirect_valid = 0; stall = 0; imem_req_ready = 1;
        @(negedge clk);
        rst = 1;
    endtask

    // kind 0: no redirect; 1: redirect when addr key is accepted; 2: redirect on accept + response together
    task automatic run(input int n, input int kind, input logic [31:0] key, input logic [31:0] tgt);
        bit acc;
        bit fired = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (fired && i == redir_at + 1) iv_after = inst_valid;
            if (q.size() > max_out) max_out = q.size();
            if (imem_rsp_valid && first_rsp < 0) first_rsp = i;
            if (inst_valid && first_iv < 0) first_iv = i;
            if (inst_valid && !stall) begin pcs.push_back(inst_pc); ins.push_back(instruction); end
            acc = imem_req_valid && imem_req_ready;
            if (acc) accs.push_back(imem_req_addr);
            redirect_valid = 0;
            if (!fired && ((kind == 1 && acc && imem_req_addr == key) || (kind == 2 && acc && imem_rsp_valid))) begin
                fired = 1; redir_at = i; redirect_valid = 1; redirect_pc = tgt;
            end
            @(negedge clk);
        end
        redirect_valid = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 0; imem_req_ready = 1;
        @(negedge clk); #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL rst_instruction: got %h want 0", instruction); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
        n_cmp++; if (misaligned_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", misaligned_fault); end
        rst = 1; #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL post_rst_addr: got %h want 0", imem_req_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL post_rst_instruction: got %h want 0", instruction); end
    endtask

    task automatic test_stream();
        lat = 1; cdata = 1;
        apply_reset(); clear_log();
        run(20, 0, 0, 0);
        n_cmp++; if (first_rsp !== 1) begin n_err++; $display("FAIL stream_first_rsp: got %0d want 1", first_rsp); end
        n_cmp++; if (first_iv !== 2) begin n_err++; $display("FAIL stream_first_iv: got %0d want 2", first_iv); end
        n_cmp++; if (max_out > 2) begin n_err++; $display("FAIL stream_outstanding: got %0d want <=2", max_out); end
        n_cmp++; if (pcs.size() < 6 || accs.size() < 6) begin n_err++; $display("FAIL stream_count: got %0d/%0d want >=6", pcs.size(), accs.size()); end
        for (int k = 0; k < 6 && k < pcs.size() && k < accs.size(); k++) begin
            n_cmp++; if (accs[k] !== 32'(4 * k)) begin n_err++; $display("FAIL stream_addr[%0d]: got %h want %h", k, accs[k], 4 * k); end
            n_cmp++; if (pcs[k] !== 32'(4 * k)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, pcs[k], 4 * k); end
            n_cmp++; if (ins[k] !== 32'h13) begin n_err++; $display("FAIL stream_inst[%0d]: got %h want 00000013", k, ins[k]); end
        end
        cdata = 0;
    endtask

    task automatic test_stall();
        lat = 1;
        apply_reset(); clear_log();
        stall = 1;
        run(4, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_req_valid[%0d]: got %b want 0", k, imem_req_valid); end
            n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_inst_valid[%0d]: got %b want 1", k, inst_valid); end
            n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL stall_inst_pc[%0d]: got %h want 0", k, inst_pc); end
            n_cmp++; if (instruction !== dfn(32'h0)) begin n_err++; $display("FAIL stall_instruction[%0d]: got %h want %h", k, instruction, dfn(32'h0)); end
            @(negedge clk);
        end
        stall = 0;
        run(16, 0, 0, 0);
        n_cmp++; if (pcs.size() < 8) begin n_err++; $display("FAIL stall_drain_count: got %0d want >=8", pcs.size()); end
        for (int k = 0; k < 8 && k < pcs.size(); k++) begin
            n_cmp++; if (pcs[k] !== 32'(4 * k) || ins[k] !== dfn(32'(4 * k))) begin
                n_err++; $display("FAIL stall_drain[%0d]: got pc %h inst %h want pc %h inst %h", k, pcs[k], ins[k], 4 * k, dfn(32'(4 * k)));
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] ea [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104};
        logic [31:0] ep [4] = '{32'h0, 32'h4, 32'h100, 32'h104};
        lat = 3;
        apply_reset(); clear_log();
        run(22, 1, 32'hC, 32'h100);
        n_cmp++; if (iv_after !== 1'b0) begin n_err++; $display("FAIL redir_iv_after: got %b want 0", iv_after); end
        n_cmp++; if (accs.size() < 6 || pcs.size() < 4) begin n_err++; $display("FAIL redir_count: got %0d/%0d want >=6/>=4", accs.size(), pcs.size()); end
        for (int k = 0; k < 6 && k < accs.size(); k++) begin
            n_cmp++; if (accs[k] !== ea[k]) begin n_err++; $display("FAIL redir_addr[%0d]: got %h want %h", k, accs[k], ea[k]); end
        end
        for (int k = 0; k < 4 && k < pcs.size(); k++) begin
            n_cmp++; if (pcs[k] !== ep[k] || ins[k] !== dfn(ep[k])) begin
                n_err++; $display("FAIL redir_pc[%0d]: got pc %h inst %h want pc %h inst %h", k, pcs[k], ins[k], ep[k], dfn(ep[k]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea [4] = '{32'h0, 32'h4, 32'h200, 32'h204};
        logic [31:0] ep [3] = '{32'h200, 32'h204, 32'h208};
        lat = 1;
        apply_reset(); clear_log();
        run(14, 2, 0, 32'h200);
        n_cmp++; if (redir_at !== 1) begin n_err++; $display("FAIL b2b_redir_cycle: got %0d want 1", redir_at); end
        n_cmp++; if (iv_after !== 1'b0) begin n_err++; $display("FAIL b2b_iv_after: got %b want 0", iv_after); end
        n_cmp++; if (accs.size() < 4 || pcs.size() < 3) begin n_err++; $display("FAIL b2b_count: got %0d/%0d want >=4/>=3", accs.size(), pcs.size()); end
        for (int k = 0; k < 4 && k < accs.size(); k++) begin
            n_cmp++; if (accs[k] !== ea[k]) begin n_err++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, accs[k], ea[k]); end
        end
        for (int k = 0; k < 3 && k < pcs.size(); k++) begin
            n_cmp++; if (pcs[k] !== ep[k] || ins[k] !== dfn(ep[k])) begin
                n_err++; $display("FAIL b2b_pc[%0d]: got pc %h inst %h want pc %h inst %h", k, pcs[k], ins[k], ep[k], dfn(ep[k]));
            end
        end
    endtask

    task automatic test_misaligned();
        lat = 2;
        apply_reset(); clear_log();
        run(2, 1, 32'h4, 32'h102);
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (misaligned_fault !== 1'b1) begin n_err++; $display("FAIL mis_fault[%0d]: got %b want 1", k, misaligned_fault); end
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mis_req_valid[%0d]: got %b want 0", k, imem_req_valid); end
            n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL mis_inst_valid[%0d]: got %b want 0", k, inst_valid); end
            @(negedge clk);
        end
        apply_reset(); clear_log();
        run(10, 0, 0, 0);
        n_cmp++; if (misaligned_fault !== 1'b0) begin n_err++; $display("FAIL mis_fault_cleared: got %b want 0", misaligned_fault); end
        n_cmp++; if (accs.size() < 1 || accs[0] !== 32'h0) begin n_err++; $display("FAIL mis_restart_addr: got %0d entries want first 0", accs.size()); end
        n_cmp++; if (pcs.size() < 2 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4) begin n_err++; $display("FAIL mis_restart_pc: got %0d entries want 0,4", pcs.size()); end
    endtask

    task automatic test_mid_reset();
        lat = 3;
        apply_reset(); clear_log();
        run(5, 0, 0, 0);
        rst = 0;
        @(negedge clk); #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (instruction !== 32'h0) begin n_err++; $display("FAIL mid_instruction: got %h want 0", instruction); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL mid_inst_pc: got %h want 0", inst_pc); end
        rst = 1; #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_err++; $display("FAIL mid_restart_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_first_cycle_iv: got %b want 0", inst_valid); end
        clear_log();
        run(16, 0, 0, 0);
        n_cmp++; if (pcs.size() < 3) begin n_err++; $display("FAIL mid_count: got %0d want >=3", pcs.size()); end
        for (int k = 0; k < 3 && k < pcs.size(); k++) begin
            n_cmp++; if (pcs[k] !== 32'(4 * k) || ins[k] !== dfn(32'(4 * k))) begin
                n_err++; $display("FAIL mid_pc[%0d]: got pc %h inst %h want pc %h", k, pcs[k], ins[k], 4 * k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_misaligned();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
